// File: rtl/f_d_reg_pkg.sv
// f_d_reg_pkg: ExcCodes and memory-map constants shared by the fetch/decode path and address checkers.
package f_d_reg_pkg;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE = 32'h0000_3000;
  localparam logic [31:0] IM_TOP = 32'h0000_6FFF;
endpackage

// File: rtl/f_d_reg_if.sv
// f_d_reg_if: fetch-side inputs and decode-side outputs of the IF/ID register.
// Counter outputs exist only when FD_STALL_CNT_EN is defined.
interface f_d_reg_if;
  logic en;
  logic flush;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic F_BD;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic D_valid;
  logic [4:0] D_ExcCode;
  logic D_BD;
`ifdef FD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  modport master (output en, flush, F_PC, F_Instr, F_BD,
                  input D_PC, D_Instr, D_valid, D_ExcCode, D_BD, stall_cnt, bubble_cnt);
  modport slave (input en, flush, F_PC, F_Instr, F_BD,
                 output D_PC, D_Instr, D_valid, D_ExcCode, D_BD, stall_cnt, bubble_cnt);
`else
  modport master (output en, flush, F_PC, F_Instr, F_BD,
                  input D_PC, D_Instr, D_valid, D_ExcCode, D_BD);
  modport slave (input en, flush, F_PC, F_Instr, F_BD,
                 output D_PC, D_Instr, D_valid, D_ExcCode, D_BD);
`endif
endinterface

// File: rtl/f_d_reg_pc_addr_chk.sv
// pc_addr_chk: combinational address fault detector (alignment plus unsigned [LO,HI] window).
module pc_addr_chk #(
  parameter logic [31:0] LO = 32'h0000_3000,
  parameter logic [31:0] HI = 32'h0000_6FFF,
  parameter logic [1:0] ALIGN = 2'b11
) (
  input  logic [31:0] i_addr,
  output logic        o_fault
);
  assign o_fault = (|(i_addr[1:0] & ALIGN)) | (i_addr < LO) | (i_addr > HI);
endmodule

// File: rtl/f_d_reg.sv
// f_d_reg: IF/ID pipeline register; fetch faults become a valid nop tagged AdEL.
// FD_STALL_CNT_EN adds saturating stall/bubble counters.
module f_d_reg
  import f_d_reg_pkg::*;
(
  input logic clk,
  input logic reset,
  f_d_reg_if.slave bus
);
  logic w_fault;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic r_valid;
  logic [4:0] r_exc;
  logic r_bd;
  pc_addr_chk #(.LO(IM_BASE), .HI(IM_TOP), .ALIGN(2'b11)) u_chk (
    .i_addr(bus.F_PC),
    .o_fault(w_fault)
  );
  // flush still captures F_PC so EPC has a meaningful value for the bubble
  always_ff @(posedge clk)
    if (reset) begin
      r_pc <= PC_RESET;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_exc <= EXC_NONE;
      r_bd <= 1'b0;
    end else if (bus.flush) begin
      r_pc <= bus.F_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_exc <= EXC_NONE;
      r_bd <= 1'b0;
    end else if (bus.en) begin
      r_pc <= bus.F_PC;
      r_instr <= w_fault ? '0 : bus.F_Instr;
      r_valid <= 1'b1;
      r_exc <= w_fault ? EXC_ADEL : EXC_NONE;
      r_bd <= bus.F_BD;
    end
  assign bus.D_PC = r_pc;
  assign bus.D_Instr = r_instr;
  assign bus.D_valid = r_valid;
  assign bus.D_ExcCode = r_exc;
  assign bus.D_BD = r_bd;
`ifdef FD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  always_ff @(posedge clk)
    if (reset) begin
      r_stall_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (!bus.flush && !bus.en && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_f_d_reg.sv
// tb_f_d_reg: directed scoreboard bench for the IF/ID register.
module tb_f_d_reg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic valid;
    logic [4:0] exc;
    logic bd;
    logic [31:0] stall;
    logic [31:0] bubble;
  } d_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  d_t q[$];
  d_t m;
  always #5 clk = ~clk;
  f_d_reg_if bus();
  f_d_reg dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic f, input logic [31:0] pc,
                      input logic [31:0] ins, input logic b);
    d_t exp;
    logic flt;
    reset = r;
    bus.en = e;
    bus.flush = f;
    bus.F_PC = pc;
    bus.F_Instr = ins;
    bus.F_BD = b;
    flt = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFF);
    if (r) m = '{pc: 32'h3000, default: '0};
    else if (f) begin
      m.pc = pc; m.instr = 0; m.valid = 0; m.exc = 0; m.bd = 0;
      if (m.bubble != 32'hFFFF_FFFF) m.bubble++;
    end else if (!e) begin
      if (m.stall != 32'hFFFF_FFFF) m.stall++;
    end else begin
      m.pc = pc; m.instr = flt ? 32'h0 : ins; m.valid = 1; m.exc = flt ? 5'd4 : 5'd0; m.bd = b;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    exp = q.pop_front();
    chk("D_PC", bus.D_PC, exp.pc);
    chk("D_Instr", bus.D_Instr, exp.instr);
    chk("D_valid", {31'd0, bus.D_valid}, {31'd0, exp.valid});
    chk("D_ExcCode", {27'd0, bus.D_ExcCode}, {27'd0, exp.exc});
    chk("D_BD", {31'd0, bus.D_BD}, {31'd0, exp.bd});
`ifdef FD_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, exp.stall);
    chk("bubble_cnt", bus.bubble_cnt, exp.bubble);
`endif
  endtask
  initial begin
    step(1, 0, 0, 32'h0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    chk("reset_pc", bus.D_PC, 32'h0000_3000);
    step(0, 1, 0, 32'h3000, 32'h2408_0001, 0);
    chk("t1_instr", bus.D_Instr, 32'h2408_0001);
    step(0, 1, 0, 32'h3004, 32'h1234_5678, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h3100 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 1);
    chk("t2_hold_pc", bus.D_PC, 32'h3004);
    chk("t2_hold_instr", bus.D_Instr, 32'h1234_5678);
`ifdef FD_STALL_CNT_EN
    chk("t2_stall3", bus.stall_cnt, 32'd3);
`endif
    step(0, 0, 1, 32'h3010, 32'hFFFF_FFFF, 1);
    chk("t3_flush_pc", bus.D_PC, 32'h3010);
`ifdef FD_STALL_CNT_EN
    chk("t3_bubble1", bus.bubble_cnt, 32'd1);
`endif
    step(0, 1, 0, 32'h3002, 32'hAAAA_5555, 0);
    chk("t4_unaligned_exc", {27'd0, bus.D_ExcCode}, 32'd4);
    step(0, 1, 0, 32'h7000, 32'h1111_1111, 0);
    step(0, 1, 0, 32'h6FFC, 32'h2222_2222, 1);
    chk("t4_top_pass", bus.D_Instr, 32'h2222_2222);
    step(0, 1, 0, 32'h2FFC, 32'h3333_3333, 0);
    step(0, 1, 0, 32'hFFFF_FFFC, 32'h4444_4444, 0);
    step(0, 1, 0, 32'h6FFF, 32'h5555_5555, 0);
    step(0, 1, 0, 32'h0000_0000, 32'h6666_6666, 0);
    step(0, 1, 0, 32'h3001, 32'h7777_7777, 1);
    step(0, 1, 0, 32'h3008, 32'h0800_0C00, 1);
    chk("t5_bd", {31'd0, bus.D_BD}, 32'd1);
    step(0, 1, 1, 32'h300C, 32'h8888_8888, 1);
    step(0, 1, 0, 32'h3003, 32'h9999_9999, 0);
    step(0, 0, 0, 32'h3020, 32'hABCD_0000, 0);
    step(0, 0, 0, 32'h3024, 32'hABCD_0001, 0);
    chk("t6_held_adel", {27'd0, bus.D_ExcCode}, 32'd4);
    step(1, 0, 0, 32'h5000, 32'hBBBB_BBBB, 1);
    chk("t6_reset_pc", bus.D_PC, 32'h0000_3000);
    step(1, 1, 1, 32'h5004, 32'hCCCC_CCCC, 1);
    step(0, 1, 0, 32'h3040, 32'h0000_0000, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/f_d_reg.md
Name: f_d_reg

Overview:
IF/ID pipeline register between the fetch stage (PC register + instruction memory) and the decode stage of the 5-stage MIPS pipeline.
- Latches the fetched PC and instruction once per cycle.
- Tags each instruction with a valid bit, a branch-delay-slot flag and a fetch exception code.
- Obeys the hazard unit's stall (en) and the CP0/branch flush.
- Any fetch address fault is converted into a nop carrying AdEL, so downstream stages see a clean bubble with the exception attached.

Parameters:
PC_RESET, 32'h0000_3000, value D_PC takes on reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_TOP, 32'h0000_6FFF, highest legal fetch byte address
EXC_ADEL, 5'd4, ExcCode for fetch address error

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  1 = load new fetch data; 0 = hold (stall from hazard unit)
flush  input  1  1 = insert bubble (exception/eret/branch-likely squash)
F_PC  input  32  PC of instruction being fetched
F_Instr  input  32  instruction word from IM
F_BD  input  1  fetched instruction is in a branch delay slot (D-stage branch decoded)
D_PC  output  32  registered PC
D_Instr  output  32  registered instruction (0 = nop when invalid/faulted)
D_valid  output  1  1 = real instruction, 0 = bubble
D_ExcCode  output  5  0 = none, EXC_ADEL = fetch fault
D_BD  output  1  registered delay-slot flag

Behaviour:
- All state updates on posedge clk; outputs come directly from flops, no combinational path from inputs to outputs.
- Priority each edge: reset > flush > !en (hold) > load.
- Reset: D_PC=PC_RESET, D_Instr=0, D_valid=0, D_ExcCode=0, D_BD=0.
- Flush (regardless of en):
  - D_PC<=F_PC, so the macroscopic PC stays meaningful for EPC.
  - D_Instr<=0, D_valid<=0, D_ExcCode<=0, D_BD<=0.
- Hold (en=0, flush=0): all outputs keep their previous value. A held AdEL stays held.
- Load (en=1, flush=0):
  - Fault condition: fault = (F_PC[1:0]!=0) || (F_PC<IM_BASE) || (F_PC>IM_TOP); compare unsigned, full 32 bits.
  - No fault: D_PC<=F_PC, D_Instr<=F_Instr, D_valid<=1, D_ExcCode<=0, D_BD<=F_BD.
  - Fault: D_PC<=F_PC, D_Instr<=0, D_valid<=1 (the instruction exists and is faulted), D_ExcCode<=EXC_ADEL, D_BD<=F_BD.
- Boundaries:
  - F_PC=IM_TOP-3 (0x6FFC) is legal.
  - 0x7000 faults.
  - 0x2FFC faults.
  - Wrap: 0xFFFF_FFFC faults.
- Latency: exactly 1 cycle from an F_* sample to the D_* outputs.
- Reset asserted mid-stall or mid-flush wins in that cycle.
- No internal state beyond the output flops, apart from the optional counters below.

Optional Feature:
Macro FD_STALL_CNT_EN.
- Defined:
  - Extra outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments on every edge with reset=0, flush=0, en=0.
  - bubble_cnt increments on every edge with reset=0 and flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ExcCode constants (EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
  - The memory-map constants PC_RESET, IM_BASE, IM_TOP, shared with the PC register and the M-stage address checker.
- One natural sub-module: pc_addr_chk, the combinational fault detector. It is reused later for E/M-stage load/store checks.
- The counters stay inline.

Test Plan:
1. Reset for 2 cycles, then en=1, F_PC=0x3000, F_Instr=0x2408_0001 -> after 1 edge: D_PC=0x3000, D_Instr=0x2408_0001, D_valid=1, D_ExcCode=0, D_BD=0.
2. Load F_PC=0x3004, F_Instr=0x1234_5678, then en=0 for 3 cycles while F_* change -> D_* stay at 0x3004/0x1234_5678; with FD_STALL_CNT_EN, stall_cnt=3.
3. en=0 and flush=1 simultaneously, F_PC=0x3010 -> D_PC=0x3010, D_Instr=0, D_valid=0, D_ExcCode=0, D_BD=0; bubble_cnt=1.
4. Fault cases, each with en=1:
   - F_PC=0x3002 -> D_Instr=0, D_valid=1, D_ExcCode=4.
   - F_PC=0x7000 -> D_ExcCode=4.
   - F_PC=0x6FFC -> D_ExcCode=0 and instruction passed through.
   - F_PC=0x2FFC -> D_ExcCode=4.
5. F_BD=1 with F_PC=0x3008 loaded -> D_BD=1; next cycle flush=1 -> D_BD=0.
6. Assert reset during a held AdEL (en=0) -> D_ExcCode=0, D_PC=0x3000, D_valid=0; counters cleared.
